// File: rtl/seq_alu.sv
// Multi-cycle ALU: logic/arith ops finish in one cycle, MOD runs a restoring divider.
// Define SEQ_ALU_QUOT_EN to add the quot output carrying floor(a/b) for MOD.
module seq_alu #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       aluop,
`ifdef SEQ_ALU_QUOT_EN
    output logic [WIDTH-1:0] quot,
`endif
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             zero,
    output logic             div0,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    state_t           state, nextState;
    logic [WIDTH-1:0] aReg, bReg;
    logic [2:0]       opReg;
    logic [WIDTH:0]   rem;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] execRes;
    logic             execCarry;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH:0]   shifted, trial, remNext;
    logic             qBit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = (aluop == OP_MOD && b != '0) ? DIV : EXEC;
            EXEC: nextState = DONE;
            DIV:  if (cnt == '0) nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_comb begin
        sum       = {1'b0, aReg} + {1'b0, bReg};
        diff      = {1'b0, aReg} - {1'b0, bReg};
        execRes   = '0;
        execCarry = 1'b0;
        case (opReg)
            OP_AND: execRes = aReg & bReg;
            OP_OR:  execRes = aReg | bReg;
            OP_XOR: execRes = aReg ^ bReg;
            OP_NOR: execRes = ~(aReg | bReg);
            OP_SLT: execRes = {{(WIDTH-1){1'b0}}, ($signed(aReg) < $signed(bReg))};
            OP_ADD: begin execRes = sum[WIDTH-1:0];  execCarry = sum[WIDTH];  end
            OP_SUB: begin execRes = diff[WIDTH-1:0]; execCarry = diff[WIDTH]; end
            default: execRes = aReg;
        endcase
    end

    // Partial remainder never exceeds b, so a negative trial shows up as its top bit.
    always_comb begin
        shifted = {rem[WIDTH-1:0], aReg[WIDTH-1]};
        trial   = shifted - {1'b0, bReg};
        qBit    = ~trial[WIDTH];
        remNext = qBit ? trial : shifted;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aReg  <= '0;
            bReg  <= '0;
            opReg <= '0;
            rem   <= '0;
            cnt   <= '0;
            res   <= '0;
            carry <= 1'b0;
            zero  <= 1'b1;
            div0  <= 1'b0;
`ifdef SEQ_ALU_QUOT_EN
            quot  <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    aReg  <= a;
                    bReg  <= b;
                    opReg <= aluop;
                    rem   <= '0;
                    cnt   <= CNT_W'(WIDTH);
                end
                EXEC: begin
                    res   <= execRes;
                    carry <= execCarry;
                    zero  <= (execRes == '0);
                    div0  <= (opReg == OP_MOD);
`ifdef SEQ_ALU_QUOT_EN
                    quot  <= (opReg == OP_MOD) ? '1 : '0;
`endif
                end
                DIV: if (cnt != '0) begin
                    rem  <= remNext;
`ifdef SEQ_ALU_QUOT_EN
                    aReg <= {aReg[WIDTH-2:0], qBit};
`else
                    aReg <= {aReg[WIDTH-2:0], 1'b0};
`endif
                    cnt  <= cnt - CNT_W'(1);
                end else begin
                    res   <= rem[WIDTH-1:0];
                    carry <= 1'b0;
                    zero  <= (rem[WIDTH-1:0] == '0);
                    div0  <= 1'b0;
`ifdef SEQ_ALU_QUOT_EN
                    quot  <= aReg;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
